// File: rtl/main_fsm.sv
// Moore control sequencer for the multicycle ARM datapath: walks each
// instruction through fetch, decode and its execute/memory/writeback states.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       InstrDone,
    output logic [3:0] State
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OUT_W   = 14;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [OUT_W-1:0]   outs_q;
    logic               done_moore;

    // Moore output decode; illegal encodings fall through to all-zero.
    function automatic logic [OUT_W-1:0] decode_outs(input state_t s);
        logic       ir_write;
        logic       adr_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       done;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        src_a      = 2'b00;
        src_b      = 2'b00;
        result_src = 2'b00;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        done       = 1'b0;
        case (s)
            FETCH: begin
                ir_write   = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                next_pc    = 1'b1;
            end
            DECODE: begin
                // PC+4 again, so R15 reads as PC+8
                src_b      = 2'b10;
                result_src = 2'b10;
            end
            MEMADR: begin
                src_a = 2'b01;
                src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                done       = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                done    = 1'b1;
            end
            EXECUTER: begin
                src_a  = 2'b01;
                alu_op = 1'b1;
            end
            EXECUTEI: begin
                src_a  = 2'b01;
                src_b  = 2'b01;
                alu_op = 1'b1;
            end
            ALUWB: begin
                reg_w = 1'b1;
                done  = 1'b1;
            end
            BRANCH: begin
                src_a      = 2'b01;
                src_b      = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
                done       = 1'b1;
            end
            default: ;
        endcase
        return {ir_write, adr_src, src_a, src_b, result_src,
                next_pc, reg_w, mem_w, branch, alu_op, done};
    endfunction

    // Next-state logic; anything unrecognised returns to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Outputs are registered from the state being entered so they track State exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            outs_q  <= decode_outs(FETCH);
        end else begin
            state_q <= state_d;
            outs_q  <= decode_outs(state_d);
        end
    end

    assign {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
            NextPC, RegW, MemW, Branch, ALUOp, done_moore} = outs_q;

    // Undefined opcodes retire in DECODE as a NOP.
    assign InstrDone = done_moore | ((state_q == DECODE) && (Op == 2'b11));
    assign State     = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed instruction classes, async reset
// abort and a random instruction stream against an instruction-level model.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'b000000;
    logic       ir_write, adr_src, next_pc, reg_w, mem_w, branch, alu_op, instr_done;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] state;
    logic [13:0] obs;

    int n_total = 0;
    int n_pass  = 0;
    int nextpc_cnt;
    int cyc_cnt;
    int seq_q[$];

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (op),
        .Funct     (funct),
        .IRWrite   (ir_write),
        .AdrSrc    (adr_src),
        .ALUSrcA   (alu_src_a),
        .ALUSrcB   (alu_src_b),
        .ResultSrc (result_src),
        .NextPC    (next_pc),
        .RegW      (reg_w),
        .MemW      (mem_w),
        .Branch    (branch),
        .ALUOp     (alu_op),
        .InstrDone (instr_done),
        .State     (state)
    );

    always #5 clk = ~clk;

    assign obs = {ir_write, adr_src, alu_src_a, alu_src_b, result_src,
                  next_pc, reg_w, mem_w, branch, alu_op, instr_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Visited states for one instruction, from the instruction class alone.
    function automatic void build_seq(input logic [1:0] o, input logic [5:0] f);
        seq_q.delete();
        seq_q.push_back(0);
        seq_q.push_back(1);
        case (o)
            2'b00: begin
                seq_q.push_back(f[5] ? 7 : 6);
                seq_q.push_back(8);
            end
            2'b01: begin
                seq_q.push_back(2);
                if (f[0]) begin
                    seq_q.push_back(3);
                    seq_q.push_back(4);
                end else begin
                    seq_q.push_back(5);
                end
            end
            2'b10: seq_q.push_back(9);
            default: ;
        endcase
    endfunction

    // Expected control word for a state; packing order matches obs.
    function automatic logic [13:0] exp_out(input int s, input logic [1:0] o);
        logic irw, adr, npc, rw, mw, br, aop, dn;
        logic [1:0] sa, sb, rs;
        {irw, adr, npc, rw, mw, br, aop, dn} = 8'h00;
        sa = 2'b00; sb = 2'b00; rs = 2'b00;
        case (s)
            0: begin irw = 1; sb = 2'b10; rs = 2'b10; npc = 1; end
            1: begin sb = 2'b10; rs = 2'b10; dn = (o == 2'b11); end
            2: begin sa = 2'b01; sb = 2'b01; end
            3: begin adr = 1; end
            4: begin rs = 2'b01; rw = 1; dn = 1; end
            5: begin adr = 1; mw = 1; dn = 1; end
            6: begin sa = 2'b01; aop = 1; end
            7: begin sa = 2'b01; sb = 2'b01; aop = 1; end
            8: begin rw = 1; dn = 1; end
            9: begin sa = 2'b01; sb = 2'b01; rs = 2'b10; br = 1; dn = 1; end
            default: ;
        endcase
        return {irw, adr, sa, sb, rs, npc, rw, mw, br, aop, dn};
    endfunction

    // Entered at a falling edge with the DUT in FETCH; leaves it back in FETCH.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input string tag);
        op    = o;
        funct = f;
        build_seq(o, f);
        foreach (seq_q[i]) begin
            check($sformatf("%s state[%0d]", tag, i), 32'(state), 32'(seq_q[i]));
            check($sformatf("%s outs[%0d]", tag, i), 32'(obs), 32'(exp_out(seq_q[i], o)));
            nextpc_cnt += int'(next_pc);
            cyc_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int mw_seq[4];
        mw_seq = '{0, 1, 2, 5};
        reset = 1'b1;
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset outs", 32'(obs), 32'(exp_out(0, 2'b00)));
        @(negedge clk);
        check("reset held state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_instr(2'b00, 6'b000100, "add_reg");
        run_instr(2'b00, 6'b100101, "subs_imm");
        run_instr(2'b01, 6'b011001, "ldr");
        run_instr(2'b01, 6'b011000, "str");
        run_instr(2'b10, 6'b000000, "b");
        run_instr(2'b11, 6'b111111, "undef");

        // Async reset in the middle of a store's MEMWRITE cycle.
        op    = 2'b01;
        funct = 6'b011000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort state[%0d]", i), 32'(state), 32'(mw_seq[i]));
            if (i < 3) @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        check("abort async state", 32'(state), 32'd0);
        check("abort memw", 32'(mem_w), 32'd0);
        check("abort outs", 32'(obs), 32'(exp_out(0, 2'b01)));
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort next edge", 32'(state), 32'd1);
        op = 2'b11;
        @(negedge clk);
        check("abort nop done", 32'(instr_done), 32'd1);
        @(negedge clk);
        check("abort back fetch", 32'(state), 32'd0);

        // Back-to-back LDR, B, ADD.
        nextpc_cnt = 0;
        cyc_cnt    = 0;
        run_instr(2'b01, 6'b011001, "b2b_ldr");
        run_instr(2'b10, 6'b000000, "b2b_b");
        run_instr(2'b00, 6'b000100, "b2b_add");
        check("b2b cycles", 32'(cyc_cnt), 32'd12);
        check("b2b nextpc", 32'(nextpc_cnt), 32'd3);
        check("b2b fetch", 32'(state), 32'd0);

        // Random stream; NextPC must fire once per instruction.
        nextpc_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            run_instr(2'($urandom_range(0, 3)), 6'($urandom), $sformatf("rnd%0d", n));
        end
        check("rnd nextpc", 32'(nextpc_cnt), 32'd60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
# main_fsm

Moore state machine that sequences the multicycle ARM datapath. Consumes the op and funct fields of the latched instruction and, every cycle, drives the datapath's IRWrite, AdrSrc, ALUSrcA, ALUSrcB and ResultSrc selects. It also drives the unconditioned write/branch enables (NextPC, RegW, MemW, Branch) and ALUOp for the condition logic and ALU decoder. Sits inside the controller beside the ALU decoder and condition-check block.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; forces state to FETCH.
- Op  input  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  input  6  Instr[25:20]: Funct[5] is I (immediate), Funct[0] is S/L (load when 1 for memory ops).
- IRWrite  output  1  latch ReadData into the instruction register.
- AdrSrc  output  1  0 = PC, 1 = Result.
- ALUSrcA  output  2  00 = PC, 01 = A register.
- ALUSrcB  output  2  00 = WriteData register, 01 = ExtImm, 10 = constant 4.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- NextPC  output  1  PC update request (ORed with a taken branch downstream).
- RegW  output  1  register-write request, before condition gating.
- MemW  output  1  memory-write request, before condition gating.
- Branch  output  1  branch request, before condition gating.
- ALUOp  output  1  1 = ALU decoder uses Funct; 0 = force ADD.
- InstrDone  output  1  high in the last cycle of every instruction.
- State  output  4  current state encoding, for debug and verification.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9.
- Encodings 10–15 are illegal. In an illegal state all outputs are 0 and the next state is FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH.
  - MEMADR: Funct[0]=1 -> MEMREAD, otherwise -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB.
- Outputs are a pure function of State (Moore). Any output not listed for a state is 0.
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=00, ALUSrcB=10, ResultSrc=10. This presents PC+8 as R15.
  - MEMADR: ALUSrcA=01, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1, InstrDone=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1, InstrDone=1.
  - EXECUTER: ALUSrcA=01, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=01, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1, InstrDone=1.
  - BRANCH: ALUSrcA=01, ALUSrcB=01, ResultSrc=10, Branch=1, InstrDone=1.
- An undefined opcode (Op=11) is a NOP. DECODE asserts InstrDone=1 when Op=11; this is the only Mealy term.
- Op and Funct are sampled only in DECODE and MEMADR. They are stable because IRWrite is 0 outside FETCH.

## Timing
- One state per clock. State register updates on the rising edge of clk.
- Reset:
  - reset high clears State to 0 (FETCH) immediately, without waiting for a clock edge.
  - While reset is high, outputs show FETCH values.
  - The first FETCH edge after reset deassertion latches the instruction and advances the PC.
- Instruction latency from entering FETCH to returning to FETCH:
  - data-processing (register or immediate): 4 cycles.
  - STR: 4 cycles.
  - LDR: 5 cycles.
  - B: 3 cycles.
  - undefined: 2 cycles.
- Reset asserted in any state aborts the instruction; no RegW or MemW is asserted after the reset edge.
- Writes (RegW, MemW, Branch) are asserted for exactly one cycle per instruction.
- NextPC is asserted for exactly one cycle, in FETCH.

## Test plan
- Reset mid-MEMWRITE, asynchronous between edges -> State=0 within the same cycle; MemW=0; next edge -> State=1.
- Op=00, Funct=6'b000100 (register ADD) -> State sequence 0,1,6,8,0; ALUOp=1 only in state 6; RegW=1 only in state 8; ALUSrcB=00 in state 6.
- Op=00, Funct=6'b100101 (immediate SUBS) -> 0,1,7,8,0; ALUSrcB=01 in state 7; InstrDone=1 only in state 8.
- Op=01, Funct=6'b011001 (LDR) -> 0,1,2,3,4,0; AdrSrc=1 in state 3; ResultSrc=01 and RegW=1 in state 4. Funct=6'b011000 (STR) -> 0,1,2,5,0 with MemW=1 in state 5.
- Op=10 -> 0,1,9,0; Branch=1, ALUSrcA=01, ALUSrcB=01, ResultSrc=10 in state 9. Op=11 -> 0,1,0 with InstrDone=1 in DECODE and no RegW, MemW or Branch.
- Back-to-back stream LDR, B, ADD-register -> 12 cycles total; NextPC high exactly 3 times, once per FETCH.
